// File: rtl/branch_predict_resolve.sv
// Branch prediction and resolution unit.
//
// Purpose:
//   IF side: predicts direction and target for the fetched PC from a direct-mapped BTB
//   holding valid/tag/target and a 2-bit saturating counter per entry.
//   EX side: detects direction and target mispredictions, produces the redirect PC and
//   flush request, trains the BTB and counts resolved control instructions and
//   mispredictions.
//
// Ports:
//   i_clk            clock, rising edge
//   i_reset          asynchronous reset, active low
//   i_pc_if          PC being fetched
//   o_pred_taken_if  predicted taken for i_pc_if
//   o_pred_pc_if     predicted next PC (BTB target or i_pc_if+4)
//   i_is_ctrl_ex     EX holds a branch/jal/jalr
//   i_is_jump_ex     EX control instruction is unconditional
//   i_stall_ex       EX held this cycle; no training, no counting
//   i_pc_sel         actual outcome, 1 = taken
//   i_pred_taken_ex  prediction carried down from IF
//   i_pred_pc_ex     predicted next PC carried down from IF
//   i_alu_data_ex    actual target address
//   i_pc_ex          PC of EX instruction
//   o_correct_pc     redirect PC: i_alu_data_ex if taken, else i_pc_ex+4
//   o_mispred_ex     misprediction in EX
//   o_flush          flush IF/ID and ID/EX, redirect fetch to o_correct_pc
//   o_ctrl_cnt       resolved control instructions
//   o_mispred_cnt    resolved mispredictions
module branch_predict_resolve #(
    parameter int unsigned IDX_W     = 6,
    parameter int unsigned TAG_W     = 8,
    parameter int unsigned CNT_W     = 32,
    parameter int unsigned PRED_MODE = 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [31:0]      i_pc_if,
    output logic             o_pred_taken_if,
    output logic [31:0]      o_pred_pc_if,
    input  logic             i_is_ctrl_ex,
    input  logic             i_is_jump_ex,
    input  logic             i_stall_ex,
    input  logic             i_pc_sel,
    input  logic             i_pred_taken_ex,
    input  logic [31:0]      i_pred_pc_ex,
    input  logic [31:0]      i_alu_data_ex,
    input  logic [31:0]      i_pc_ex,
    output logic [31:0]      o_correct_pc,
    output logic             o_mispred_ex,
    output logic             o_flush,
    output logic [CNT_W-1:0] o_ctrl_cnt,
    output logic [CNT_W-1:0] o_mispred_cnt
);

    localparam int unsigned ENTRIES = 1 << IDX_W;
    localparam bit          DYN     = (PRED_MODE != 0);

    logic [ENTRIES-1:0] r_valid;
    logic [TAG_W-1:0]   r_tag    [ENTRIES];
    logic [31:0]        r_target [ENTRIES];
    logic [1:0]         r_ctr    [ENTRIES];
    logic [CNT_W-1:0]   r_ctrl_cnt;
    logic [CNT_W-1:0]   r_mispred_cnt;

    logic [IDX_W-1:0] w_if_idx;
    logic [TAG_W-1:0] w_if_tag;
    logic             w_if_hit;
    logic [IDX_W-1:0] w_ex_idx;
    logic [TAG_W-1:0] w_ex_tag;
    logic             w_ex_hit;
    logic             w_dir_mis;
    logic             w_tgt_mis;
    logic             w_resolve;
    logic             w_train;
    logic [1:0]       w_hit_ctr;
    logic [1:0]       w_ex_ctr;
    logic             w_unused_pc;

    // ---------------- IF prediction ----------------
    assign w_if_idx = i_pc_if[IDX_W+1:2];
    assign w_if_tag = i_pc_if[IDX_W+2 +: TAG_W];
    assign w_if_hit = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);

    // Gating with i_reset keeps the prediction not-taken for the whole reset window.
    assign o_pred_taken_if = DYN && i_reset && w_if_hit && r_ctr[w_if_idx][1];
    assign o_pred_pc_if    = o_pred_taken_if ? r_target[w_if_idx] : (i_pc_if + 32'd4);

    // ---------------- EX resolution ----------------
    assign w_dir_mis    = (i_pc_sel != i_pred_taken_ex);
    assign w_tgt_mis    = i_pc_sel && i_pred_taken_ex && (i_pred_pc_ex != i_alu_data_ex);
    assign o_mispred_ex = i_is_ctrl_ex && (w_dir_mis || w_tgt_mis);
    assign o_flush      = o_mispred_ex && !i_stall_ex;
    assign o_correct_pc = i_pc_sel ? i_alu_data_ex : (i_pc_ex + 32'd4);

    assign w_resolve = i_is_ctrl_ex && !i_stall_ex;
    assign w_train   = w_resolve && DYN;

    assign w_ex_idx = i_pc_ex[IDX_W+1:2];
    assign w_ex_tag = i_pc_ex[IDX_W+2 +: TAG_W];
    assign w_ex_hit = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);
    assign w_ex_ctr = r_ctr[w_ex_idx];

    // Low PC bits and bits above the tag do not take part in indexing.
    assign w_unused_pc = ^{i_pc_if, i_pc_ex};

    // Next counter value for a hit entry.
    always_comb begin
        w_hit_ctr = w_ex_ctr;
        if (i_is_jump_ex) begin
            w_hit_ctr = 2'd3;
        end else if (i_pc_sel) begin
            if (w_ex_ctr != 2'd3) w_hit_ctr = w_ex_ctr + 2'd1;
        end else begin
            if (w_ex_ctr != 2'd0) w_hit_ctr = w_ex_ctr - 2'd1;
        end
    end

    // ---------------- BTB storage ----------------
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_valid <= '0;
            for (int i = 0; i < int'(ENTRIES); i++) begin
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= 2'b01;
            end
        end else if (w_train) begin
            if (w_ex_hit) begin
                r_ctr[w_ex_idx] <= w_hit_ctr;
                if (i_pc_sel) r_target[w_ex_idx] <= i_alu_data_ex;
            end else if (i_pc_sel) begin
                // Taken miss allocates, evicting whatever alias held the slot.
                r_valid[w_ex_idx]  <= 1'b1;
                r_tag[w_ex_idx]    <= w_ex_tag;
                r_target[w_ex_idx] <= i_alu_data_ex;
                r_ctr[w_ex_idx]    <= i_is_jump_ex ? 2'd3 : 2'd2;
            end
        end
    end

    // ---------------- Statistics ----------------
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_ctrl_cnt    <= '0;
            r_mispred_cnt <= '0;
        end else if (w_resolve) begin
            r_ctrl_cnt <= r_ctrl_cnt + CNT_W'(1);
            if (o_mispred_ex) r_mispred_cnt <= r_mispred_cnt + CNT_W'(1);
        end
    end

    assign o_ctrl_cnt    = r_ctrl_cnt;
    assign o_mispred_cnt = r_mispred_cnt;

endmodule
